// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequencer for the multi-cycle mult/div units and the HI/LO registers.
//
// A one-cycle `start` in IDLE launches an operation. The block then runs the
// selected unit for a fixed number of cycles, writes HI/LO, and pulses `done`.
// A divide with a zero divisor skips the run and raises a one-cycle `dbz_exc`.
//
// Ports:
//   clk          in  system clock, rising edge
//   reset        in  asynchronous reset, active-low
//   start        in  operation request (sampled only in IDLE)
//   op           in  0 = mult, 1 = div (sampled with start)
//   div_by_zero  in  divisor-is-zero flag from the div unit (sampled with start)
//   multControl  out mult unit run enable
//   divControl   out div unit run enable
//   muxHiControl out HI source select (0 = mult, 1 = div)
//   muxLoControl out LO source select (0 = mult, 1 = div)
//   HiWrite      out HI register write enable
//   LoWrite      out LO register write enable
//   busy         out operation in progress
//   done         out one-cycle completion pulse
//   dbz_exc      out one-cycle divide-by-zero exception request
module muldiv_ctrl #(
  parameter int MULT_CYCLES = 32,
  parameter int DIV_CYCLES  = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic op,
  input  logic div_by_zero,
  output logic multControl,
  output logic divControl,
  output logic muxHiControl,
  output logic muxLoControl,
  output logic HiWrite,
  output logic LoWrite,
  output logic busy,
  output logic done,
  output logic dbz_exc
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    WRITE = 2'd2,
    EXC   = 2'd3
  } stateE;

  stateE            state;
  logic             opQ;
  logic [CNT_W-1:0] cnt;

  // Selects follow the last accepted op and are held through IDLE.
  assign muxHiControl = opQ;
  assign muxLoControl = opQ;

  // Outputs are registered alongside the state: each branch sets the values
  // that belong to the state being entered, so they line up with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      opQ         <= 1'b0;
      cnt         <= '0;
      multControl <= 1'b0;
      divControl  <= 1'b0;
      HiWrite     <= 1'b0;
      LoWrite     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      dbz_exc     <= 1'b0;
    end else begin
      multControl <= 1'b0;
      divControl  <= 1'b0;
      HiWrite     <= 1'b0;
      LoWrite     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      dbz_exc     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            opQ  <= op;
            busy <= 1'b1;
            if (op && div_by_zero) begin
              state   <= EXC;
              dbz_exc <= 1'b1;
            end else begin
              state       <= RUN;
              cnt         <= op ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
              multControl <= ~op;
              divControl  <= op;
            end
          end
        end
        RUN: begin
          busy <= 1'b1;
          if (cnt == '0) begin
            state   <= WRITE;
            HiWrite <= 1'b1;
            LoWrite <= 1'b1;
            done    <= 1'b1;
          end else begin
            cnt         <= cnt - CNT_W'(1);
            multControl <= ~opQ;
            divControl  <= opQ;
          end
        end
        WRITE:   state <= IDLE;
        EXC:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Testbench for muldiv_ctrl: two instances (default counts and MULT=1/DIV=3)
// share one stimulus stream; each is compared every cycle against a model that
// predicts outputs from the accepted start cycle and the cycle count.
module tb_muldiv_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic op = 1'b0;
  logic divByZero = 1'b0;

  logic multC [2];
  logic divC  [2];
  logic muxHi [2];
  logic muxLo [2];
  logic hiW   [2];
  logic loW   [2];
  logic busyO [2];
  logic doneO [2];
  logic excO  [2];
  logic [8:0] outs [2];

  always #5 clk = ~clk;

  muldiv_ctrl dutA (
    .clk(clk), .reset(reset), .start(start), .op(op), .div_by_zero(divByZero),
    .multControl(multC[0]), .divControl(divC[0]),
    .muxHiControl(muxHi[0]), .muxLoControl(muxLo[0]),
    .HiWrite(hiW[0]), .LoWrite(loW[0]),
    .busy(busyO[0]), .done(doneO[0]), .dbz_exc(excO[0])
  );

  muldiv_ctrl #(.MULT_CYCLES(1), .DIV_CYCLES(3)) dutB (
    .clk(clk), .reset(reset), .start(start), .op(op), .div_by_zero(divByZero),
    .multControl(multC[1]), .divControl(divC[1]),
    .muxHiControl(muxHi[1]), .muxLoControl(muxLo[1]),
    .HiWrite(hiW[1]), .LoWrite(loW[1]),
    .busy(busyO[1]), .done(doneO[1]), .dbz_exc(excO[1])
  );

  for (genvar g = 0; g < 2; g++) begin : gPack
    assign outs[g] = {multC[g], divC[g], muxHi[g], muxLo[g], hiW[g], loW[g],
                      busyO[g], doneO[g], excO[g]};
  end

  int testsRun = 0;
  int testsFailed = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: each instance remembers its last accepted operation.
  int multN [2] = '{32, 1};
  int divN  [2] = '{32, 3};
  int cyc = 0;
  bit act  [2];
  int sCyc [2];
  int nCyc [2];
  bit opM  [2];
  bit dbzM [2];

  function automatic bit isFree(int k, int c);
    int d;
    if (!act[k]) return 1'b1;
    d = c - sCyc[k];
    return dbzM[k] ? (d >= 2) : (d >= nCyc[k] + 2);
  endfunction

  // Order: {mult, div, muxHi, muxLo, HiWrite, LoWrite, busy, done, dbz_exc}
  function automatic logic [8:0] expOut(int k, int c);
    logic [8:0] e;
    int d;
    e = {2'b00, opM[k], opM[k], 5'b00000};
    if (act[k]) begin
      d = c - sCyc[k];
      if (dbzM[k]) begin
        if (d == 1) e[2] = 1'b1;
        if (d == 1) e[0] = 1'b1;
      end else if (d >= 1 && d <= nCyc[k]) begin
        e[8] = ~opM[k];
        e[7] = opM[k];
        e[2] = 1'b1;
      end else if (d == nCyc[k] + 1) begin
        e[4] = 1'b1;
        e[3] = 1'b1;
        e[2] = 1'b1;
        e[1] = 1'b1;
      end
    end
    return e;
  endfunction

  function automatic void modelReset();
    for (int k = 0; k < 2; k++) begin
      act[k] = 1'b0;
      opM[k] = 1'b0;
    end
  endfunction

  // One cycle: check outputs of the current cycle mid-cycle, drive inputs,
  // then let the model take the same edge the DUTs take.
  task automatic step(input bit st, input bit o, input bit z);
    @(negedge clk);
    checkVal("outsA", outs[0], expOut(0, cyc));
    checkVal("outsB", outs[1], expOut(1, cyc));
    start = st;
    op = o;
    divByZero = z;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (st && isFree(k, cyc)) begin
        act[k]  = 1'b1;
        sCyc[k] = cyc;
        opM[k]  = o;
        dbzM[k] = o & z;
        nCyc[k] = o ? divN[k] : multN[k];
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    modelReset();
    #2 reset = 1'b0;
    #1;
    checkVal("rstA", outs[0], 9'd0);
    checkVal("rstB", outs[1], 9'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // mult, div, div-by-zero
    step(1'b1, 1'b0, 1'b0); idle(40);
    step(1'b1, 1'b1, 1'b0); idle(40);
    step(1'b1, 1'b1, 1'b1); idle(5);

    // starts during a mult, at cycles 5, 33 and 34 relative to the accepted one
    step(1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 36; i++) step(i == 5 || i == 33 || i == 34, 1'b1, 1'b0);
    idle(40);

    // reset asserted between edges during cycle 10 of a div
    step(1'b1, 1'b1, 1'b0);
    idle(9);
    #3 reset = 1'b0;
    #1;
    checkVal("midRstA", outs[0], 9'd0);
    checkVal("midRstB", outs[1], 9'd0);
    modelReset();
    @(negedge clk);
    reset = 1'b1;
    idle(3);
    step(1'b1, 1'b0, 1'b0); idle(40);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 3) == 0);
    end
    idle(40);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
